// File: rtl/rc5_pkg.sv
// RC5-32 constants, FSM state encoding and word helpers shared by the RC5 encrypt/decrypt cores.
package rc5_pkg;

  localparam int unsigned W         = 32;
  localparam int unsigned ROUNDS    = 12;
  localparam int unsigned T         = 2 * ROUNDS + 2;
  localparam int unsigned C         = 4;
  localparam int unsigned MIX_ITERS = 3 * T;
  localparam int unsigned KEY_W     = W * C;
  localparam int unsigned ROT_W     = 5;

  localparam logic [W-1:0] P32 = 32'hB7E1_5163;
  localparam logic [W-1:0] Q32 = 32'h9E37_79B9;

  typedef logic [W-1:0] word_t;

  // A occupies the low word, B the high word, on both din and dout.
  typedef struct packed {
    word_t b;
    word_t a;
  } rc5_blk_t;

  typedef enum logic [2:0] {
    ST_NOKEY = 3'd0,
    ST_KINIT = 3'd1,
    ST_KMIX  = 3'd2,
    ST_READY = 3'd3,
    ST_ROUND = 3'd4,
    ST_FINAL = 3'd5
  } rc5_state_e;

  function automatic word_t rotl(input word_t x, input logic [ROT_W-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  function automatic word_t rotr(input word_t x, input logic [ROT_W-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

endpackage

// File: rtl/rc5_dec_core_if.sv
// Key-load and block handshake bundle between a host and the RC5 decrypt core.
interface rc5_dec_core_if;
  import rc5_pkg::*;

  logic [KEY_W-1:0] key;
  logic             key_ld;
  logic             key_rdy;
  logic             key_valid;
  rc5_blk_t         din;
  logic             di_vld;
  logic             di_rdy;
  rc5_blk_t         dout;
  logic             do_vld;
  logic             do_rdy;

  modport slave (
    input  key, key_ld, din, di_vld, do_rdy,
    output key_rdy, key_valid, di_rdy, dout, do_vld
  );

  modport master (
    output key, key_ld, din, di_vld, do_rdy,
    input  key_rdy, key_valid, di_rdy, dout, do_vld
  );

endinterface

// File: rtl/rc5_key_sched.sv
// RC5-32 key expansion: S/L tables, KINIT fill and one KMIX iteration per cycle,
// plus the round-key read port used by the decrypt datapath.
module rc5_key_sched
  import rc5_pkg::*;
#(
  parameter int unsigned NUM_S = T,
  parameter int unsigned R_W   = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             init_i,
  input  logic             mix_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [R_W-1:0]   rnd_i,
  output word_t            s_even_c_o,
  output word_t            s_odd_c_o,
  output word_t            s0_o,
  output word_t            s1_o,
  output logic             mix_last_c_o
);

  localparam int unsigned S_IDX_W = $clog2(NUM_S);
  localparam int unsigned L_IDX_W = $clog2(C);
  localparam int unsigned MIX_N   = 3 * ((NUM_S > C) ? NUM_S : C);
  localparam int unsigned CNT_W   = $clog2(MIX_N);

  word_t               s_q [NUM_S];
  word_t               s_d [NUM_S];
  word_t               l_q [C];
  word_t               l_d [C];
  word_t               x_q, x_d, y_q, y_d;
  logic [S_IDX_W-1:0]  i_q, i_d;
  logic [L_IDX_W-1:0]  j_q, j_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  word_t               x_new, xy, y_new;
  logic [S_IDX_W-1:0]  idx_even, idx_odd;

  assign idx_even     = S_IDX_W'({rnd_i, 1'b0});
  assign idx_odd      = {idx_even[S_IDX_W-1:1], 1'b1};
  assign s_even_c_o   = s_q[idx_even];
  assign s_odd_c_o    = s_q[idx_odd];
  assign s0_o         = s_q[0];
  assign s1_o         = s_q[1];
  assign mix_last_c_o = (cnt_q == CNT_W'(MIX_N - 1));

  // Y uses the freshly updated X within the same iteration.
  always_comb begin
    s_d   = s_q;
    l_d   = l_q;
    x_d   = x_q;
    y_d   = y_q;
    i_d   = i_q;
    j_d   = j_q;
    cnt_d = cnt_q;
    x_new = rotl(s_q[i_q] + x_q + y_q, ROT_W'(3));
    xy    = x_new + y_q;
    y_new = rotl(l_q[j_q] + xy, xy[ROT_W-1:0]);
    if (load_i) begin
      for (int unsigned k = 0; k < C; k++) l_d[k] = key_i[W*k +: W];
    end
    if (init_i) begin
      for (int unsigned k = 0; k < NUM_S; k++) s_d[k] = P32 + W'(k) * Q32;
      x_d   = '0;
      y_d   = '0;
      i_d   = '0;
      j_d   = '0;
      cnt_d = '0;
    end else if (mix_i) begin
      s_d[i_q] = x_new;
      l_d[j_q] = y_new;
      x_d      = x_new;
      y_d      = y_new;
      i_d      = (i_q == S_IDX_W'(NUM_S - 1)) ? '0 : i_q + 1'b1;
      j_d      = (j_q == L_IDX_W'(C - 1)) ? '0 : j_q + 1'b1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned k = 0; k < NUM_S; k++) s_q[k] <= '0;
      for (int unsigned k = 0; k < C; k++) l_q[k] <= '0;
      x_q   <= '0;
      y_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      l_q   <= l_d;
      x_q   <= x_d;
      y_q   <= y_d;
      i_q   <= i_d;
      j_q   <= j_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rc5_dec_core.sv
// RC5-32/ROUNDS/16 block decryptor: on-chip key expansion, one decrypt round per
// cycle, valid/ready handshakes on both the input and output side.
module rc5_dec_core #(
  parameter int unsigned ROUNDS = rc5_pkg::ROUNDS
) (
  input  logic           clk,
  input  logic           clr,
  rc5_dec_core_if.slave  dec_if
);
  import rc5_pkg::*;

  localparam int unsigned NUM_S = 2 * ROUNDS + 2;
  localparam int unsigned R_W   = $clog2(ROUNDS + 1);

  rc5_state_e     state_q, state_d;
  word_t          a_q, a_d, b_q, b_d;
  logic [R_W-1:0] r_q, r_d;
  rc5_blk_t       dout_q, dout_d;
  logic           do_vld_q, do_vld_d;
  logic           key_valid_q, key_valid_d;

  logic           key_rdy_c, key_acc_c, di_rdy_c, di_acc_c;
  logic           ks_init_c, ks_mix_c, mix_last_c;
  word_t          s_even_c, s_odd_c, s0, s1;
  word_t          a_rnd, b_rnd;

  assign key_rdy_c = ((state_q == ST_NOKEY) || (state_q == ST_READY)) && !do_vld_q;
  assign key_acc_c = dec_if.key_ld && key_rdy_c;
  // A pending key load takes priority over new data in the same cycle.
  assign di_rdy_c  = (state_q == ST_READY) && !do_vld_q && !dec_if.key_ld;
  assign di_acc_c  = dec_if.di_vld && di_rdy_c;

  assign dec_if.key_rdy   = key_rdy_c;
  assign dec_if.key_valid = key_valid_q;
  assign dec_if.di_rdy    = di_rdy_c;
  assign dec_if.dout      = dout_q;
  assign dec_if.do_vld    = do_vld_q;

  rc5_key_sched #(
    .NUM_S (NUM_S),
    .R_W   (R_W)
  ) u_key_sched (
    .clk          (clk),
    .clr          (clr),
    .load_i       (key_acc_c),
    .init_i       (ks_init_c),
    .mix_i        (ks_mix_c),
    .key_i        (dec_if.key),
    .rnd_i        (r_q),
    .s_even_c_o   (s_even_c),
    .s_odd_c_o    (s_odd_c),
    .s0_o         (s0),
    .s1_o         (s1),
    .mix_last_c_o (mix_last_c)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_NOKEY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NOKEY: if (key_acc_c) state_d = ST_KINIT;
      ST_KINIT: state_d = ST_KMIX;
      ST_KMIX:  if (mix_last_c) state_d = ST_READY;
      ST_READY: begin
        if (key_acc_c)     state_d = ST_KINIT;
        else if (di_acc_c) state_d = ST_ROUND;
      end
      ST_ROUND: if (r_q == R_W'(1)) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_READY;
      default:  state_d = ST_NOKEY;
    endcase
  end

  // Decrypt round r: B undone first, then A using the new B.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    dout_d      = dout_q;
    do_vld_d    = do_vld_q;
    key_valid_d = key_valid_q;
    ks_init_c   = 1'b0;
    ks_mix_c    = 1'b0;
    b_rnd       = rotr(b_q - s_odd_c, a_q[ROT_W-1:0]) ^ a_q;
    a_rnd       = rotr(a_q - s_even_c, b_rnd[ROT_W-1:0]) ^ b_rnd;
    if (do_vld_q && dec_if.do_rdy) do_vld_d = 1'b0;
    if (key_acc_c) key_valid_d = 1'b0;
    case (state_q)
      ST_KINIT: ks_init_c = 1'b1;
      ST_KMIX: begin
        ks_mix_c = 1'b1;
        if (mix_last_c) key_valid_d = 1'b1;
      end
      ST_READY: begin
        if (di_acc_c) begin
          a_d = dec_if.din.a;
          b_d = dec_if.din.b;
          r_d = R_W'(ROUNDS);
        end
      end
      ST_ROUND: begin
        a_d = a_rnd;
        b_d = b_rnd;
        r_d = r_q - 1'b1;
      end
      ST_FINAL: begin
        dout_d.b = b_q - s1;
        dout_d.a = a_q - s0;
        do_vld_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      dout_q      <= '0;
      do_vld_q    <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      dout_q      <= dout_d;
      do_vld_q    <= do_vld_d;
      key_valid_q <= key_valid_d;
    end
  end

endmodule

// File: tb/tb_rc5_dec_core.sv
// Self-checking bench for rc5_dec_core: behavioural RC5 encrypt model feeds a
// vector table and random blocks; a queue scoreboard checks every output.
module tb_rc5_dec_core;

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  logic clk;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ms [26];
  logic [63:0] exp_q [$];
  vec_t        vecs [8];

  rc5_dec_core_if dif ();

  rc5_dec_core #(.ROUNDS(12)) dut (
    .clk    (clk),
    .clr    (clr),
    .dec_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {63'd0, act}, {63'd0, exp});
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [31:0] n);
    int s;
    s = int'(n[4:0]);
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] l [4];
    logic [31:0] a, b;
    int i, j;
    for (int q = 0; q < 4; q++) l[q] = k[32*q +: 32];
    ms[0] = 32'hB7E15163;
    for (int q = 1; q < 26; q++) ms[q] = ms[q-1] + 32'h9E3779B9;
    a = '0; b = '0; i = 0; j = 0;
    for (int q = 0; q < 78; q++) begin
      a = rol(ms[i] + a + b, 32'd3);
      ms[i] = a;
      b = rol(l[j] + a + b, a + b);
      l[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  function automatic logic [63:0] model_enc(input logic [63:0] pt);
    logic [31:0] a, b;
    a = pt[31:0] + ms[0];
    b = pt[63:32] + ms[1];
    for (int r = 1; r <= 12; r++) begin
      a = rol(a ^ b, b) + ms[2*r];
      b = rol(b ^ a, a) + ms[2*r+1];
    end
    return {b, a};
  endfunction

  // Scoreboard: every completed output transfer is compared in order.
  always @(negedge clk) begin
    if (clr && dif.do_vld && dif.do_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h with no block outstanding", dif.dout);
      end else begin
        chk("dout", dif.dout, exp_q.pop_front());
      end
    end
  end

  task automatic load_key(input logic [127:0] k);
    int n;
    model_expand(k);
    @(posedge clk); #1;
    dif.key = k;
    dif.key_ld = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dif.key_rdy && n < 200) begin @(negedge clk); n++; end
    if (!dif.key_rdy) begin
      checks++; errors++;
      $display("FAIL key_rdy_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    dif.key_ld = 1'b0;
    n = 1;
    @(negedge clk);
    chk1("key_valid_drop", dif.key_valid, 1'b0);
    chk1("key_rdy_busy", dif.key_rdy, 1'b0);
    while (!dif.key_valid && n < 200) begin @(negedge clk); n++; end
    chk("key_expand_cycles", 64'(n), 64'd80);
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] e);
    int n;
    @(posedge clk); #1;
    dif.din = d;
    dif.di_vld = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dif.di_rdy && n < 200) begin @(negedge clk); n++; end
    if (!dif.di_rdy) begin
      checks++; errors++;
      $display("FAIL send_timeout: di_rdy got 0 expected 1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    dif.di_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          n;
    logic        bad;
    logic [63:0] pt, pt2, ct, held;
    logic [63:0] pts [8];
    logic [127:0] k2;

    clr = 1'b0;
    dif.key = '0;
    dif.key_ld = 1'b0;
    dif.din = '0;
    dif.di_vld = 1'b0;
    dif.do_rdy = 1'b1;
    #2;
    chk1("rst_do_vld", dif.do_vld, 1'b0);
    chk("rst_dout", dif.dout, 64'd0);
    chk1("rst_key_valid", dif.key_valid, 1'b0);
    chk1("rst_key_rdy", dif.key_rdy, 1'b1);
    chk1("rst_di_rdy", dif.di_rdy, 1'b0);
    @(negedge clk); @(negedge clk);
    clr = 1'b1;

    // Data offered before any key must never be taken.
    dif.din = 64'h0123_4567_89AB_CDEF;
    dif.di_vld = 1'b1;
    bad = 1'b0;
    repeat (10) begin @(negedge clk); if (dif.di_rdy || dif.do_vld) bad = 1'b1; end
    chk1("nokey_di_rdy", bad, 1'b0);
    chk1("nokey_key_rdy", dif.key_rdy, 1'b1);
    dif.di_vld = 1'b0;

    // Published RC5-32/12/16 vector: all-zero key, zero plaintext.
    load_key('0);
    send(64'h6d8f4b15_eedba521, 64'h0);
    repeat (13) @(negedge clk);
    chk1("kat_before_edge13", dif.do_vld, 1'b0);
    @(negedge clk);
    chk1("kat_at_edge13", dif.do_vld, 1'b1);
    drain();

    load_key(128'h1);
    pts[0] = 64'h0000_0000_0000_0000;
    pts[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    pts[2] = 64'h0123_4567_89AB_CDEF;
    pts[3] = 64'h8000_0000_0000_0001;
    pts[4] = 64'h0000_0020_0000_0040;
    pts[5] = 64'hDEAD_BEEF_CAFE_F00D;
    pts[6] = 64'h0000_0001_0000_0000;
    pts[7] = 64'hA5A5_A5A5_5A5A_5A5A;
    for (int k = 0; k < 8; k++) begin
      vecs[k].din = model_enc(pts[k]);
      vecs[k].exp = pts[k];
    end
    for (int k = 0; k < 8; k++) send(vecs[k].din, vecs[k].exp);
    drain();

    repeat (100) begin
      pt = {$urandom, $urandom};
      send(model_enc(pt), pt);
    end
    drain();

    // Output backpressure with a second block waiting.
    dif.do_rdy = 1'b0;
    pt = 64'h0F1E_2D3C_4B5A_6978;
    send(model_enc(pt), pt);
    n = 0;
    while (!dif.do_vld && n < 50) begin @(negedge clk); n++; end
    chk1("bp_out_seen", dif.do_vld, 1'b1);
    held = dif.dout;
    chk("bp_dout_value", held, pt);
    pt2 = 64'h1122_3344_5566_7788;
    dif.din = model_enc(pt2);
    dif.di_vld = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dif.dout !== held || !dif.do_vld || dif.di_rdy) bad = 1'b1;
    end
    chk1("bp_hold", bad, 1'b0);
    @(posedge clk); #1;
    dif.do_rdy = 1'b1;
    @(negedge clk);
    chk1("bp_release_vld", dif.do_vld, 1'b1);
    chk1("bp_release_di_rdy", dif.di_rdy, 1'b0);
    @(negedge clk);
    chk1("bp_vld_drop", dif.do_vld, 1'b0);
    chk1("bp_di_rdy_rise", dif.di_rdy, 1'b1);
    if (dif.di_rdy) exp_q.push_back(pt2);
    @(posedge clk); #1;
    dif.di_vld = 1'b0;
    drain();

    // Key load and data in the same READY cycle: key wins, data waits for re-expansion.
    k2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    model_expand(k2);
    pt = 64'hCAFE_BABE_00C0_FFEE;
    ct = model_enc(pt);
    @(posedge clk); #1;
    dif.key = k2;
    dif.key_ld = 1'b1;
    dif.din = ct;
    dif.di_vld = 1'b1;
    @(negedge clk);
    chk1("coll_di_rdy", dif.di_rdy, 1'b0);
    chk1("coll_key_rdy", dif.key_rdy, 1'b1);
    @(posedge clk); #1;
    dif.key_ld = 1'b0;
    n = 1;
    @(negedge clk);
    chk1("coll_key_valid_drop", dif.key_valid, 1'b0);
    while (!dif.di_rdy && n < 200) begin @(negedge clk); n++; end
    chk("coll_accept_delay", 64'(n), 64'd80);
    if (dif.di_rdy) exp_q.push_back(pt);
    @(posedge clk); #1;
    dif.di_vld = 1'b0;
    drain();

    // Asynchronous reset during round 6 aborts the block.
    pt = 64'h5555_AAAA_3333_CCCC;
    send(model_enc(pt), pt);
    repeat (7) @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    chk1("mid_rst_do_vld", dif.do_vld, 1'b0);
    chk("mid_rst_dout", dif.dout, 64'd0);
    chk1("mid_rst_key_valid", dif.key_valid, 1'b0);
    chk1("mid_rst_key_rdy", dif.key_rdy, 1'b1);
    chk1("mid_rst_di_rdy", dif.di_rdy, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    clr = 1'b1;
    dif.din = model_enc(pt);
    dif.di_vld = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (dif.di_rdy || dif.do_vld || dif.key_valid) bad = 1'b1;
    end
    chk1("post_rst_idle", bad, 1'b0);
    dif.di_vld = 1'b0;
    load_key(k2);
    send(model_enc(pt), pt);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
